// File: rtl/fifo72_tx_arbiter_if.sv
// Bus bundle for the 72-bit frame arbiter: two source FIFO read ports,
// one shared TX FIFO write port and the status counters.
interface fifo72_tx_arbiter_if;
  logic [71:0] src0_dout;
  logic        src0_empty;
  logic        src0_rd_en;
  logic [71:0] src1_dout;
  logic        src1_empty;
  logic        src1_rd_en;
  logic [71:0] dst_din;
  logic        dst_wr_en;
  logic        dst_full;
  logic [15:0] frames0;
  logic [15:0] frames1;
  logic        trunc_err;

  // arbiter side
  modport master (
    input  src0_dout, src0_empty, src1_dout, src1_empty, dst_full,
    output src0_rd_en, src1_rd_en, dst_din, dst_wr_en, frames0, frames1, trunc_err
  );

  // FIFO / environment side
  modport slave (
    output src0_dout, src0_empty, src1_dout, src1_empty, dst_full,
    input  src0_rd_en, src1_rd_en, dst_din, dst_wr_en, frames0, frames1, trunc_err
  );
endinterface

// File: rtl/fifo72_tx_arbiter.sv
// Frame-level round-robin arbiter: copies whole frames from two 72-bit
// source FIFOs into one shared TX FIFO, truncating over-long frames with
// a 72'h0 terminator and discarding their tail.
module fifo72_tx_arbiter #(
  parameter int MAX_WORDS = 190
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  fifo72_tx_arbiter_if.master  bus
);
  localparam int CW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {IDLE, RD, WR, WAIT, TERM, DRD, DWR} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_grant, w_grant_nxt;
  logic          r_last_grant, w_last_nxt;
  logic [CW-1:0] r_word_cnt, w_cnt_nxt, w_cnt_inc;
  logic [15:0]   r_frames0, w_frames0_nxt;
  logic [15:0]   r_frames1, w_frames1_nxt;
  logic [71:0]   w_src_dout;
  logic          w_src_empty, w_eof, w_ready, w_rd, w_wr, w_term_go;

  // Mux the granted source; bit 71 low marks the last word of a frame.
  always_comb begin
    w_src_dout  = r_grant ? bus.src1_dout  : bus.src0_dout;
    w_src_empty = r_grant ? bus.src1_empty : bus.src0_empty;
    w_eof       = ~w_src_dout[71];
    w_ready     = ~w_src_empty & ~bus.dst_full;
    w_cnt_inc   = r_word_cnt + 1'b1;
    // Terminator is written only when TX has room and the tail to discard
    // is already available, so DRD never strobes an empty FIFO.
    w_term_go   = (r_state == TERM) & ~bus.dst_full & ~w_src_empty;
  end

  // State, grant and counter registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_word_cnt   <= '0;
      r_frames0    <= '0;
      r_frames1    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_word_cnt   <= w_cnt_nxt;
      r_frames0    <= w_frames0_nxt;
      r_frames1    <= w_frames1_nxt;
    end
  end

  // Next-state logic: grant is chosen only in IDLE and held to EOF.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_last_nxt    = r_last_grant;
    w_cnt_nxt     = r_word_cnt;
    w_frames0_nxt = r_frames0;
    w_frames1_nxt = r_frames1;
    unique case (r_state)
      IDLE: begin
        if (!bus.dst_full && (!bus.src0_empty || !bus.src1_empty)) begin
          w_state_nxt = RD;
          if (!bus.src0_empty && !bus.src1_empty) w_grant_nxt = ~r_last_grant;
          else                                    w_grant_nxt = bus.src0_empty;
        end
      end
      RD: w_state_nxt = WR;
      WR: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_eof) begin
          if (r_grant) w_frames1_nxt = r_frames1 + 16'd1;
          else         w_frames0_nxt = r_frames0 + 16'd1;
          w_last_nxt  = r_grant;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (w_cnt_inc == CW'(MAX_WORDS)) begin
          w_state_nxt = TERM;
        end else if (w_ready) begin
          w_state_nxt = RD;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: if (w_ready) w_state_nxt = RD;
      TERM: begin
        if (w_term_go) begin
          w_cnt_nxt   = '0;
          w_state_nxt = DRD;
        end
      end
      DRD: w_state_nxt = DWR;
      DWR: begin
        if (w_eof) begin
          w_last_nxt  = r_grant;
          w_state_nxt = IDLE;
        end else if (!w_src_empty) begin
          w_state_nxt = DRD;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Strobes and data are decoded straight from state.
  always_comb begin
    w_rd           = (r_state == RD) | (r_state == DRD);
    w_wr           = (r_state == WR) | w_term_go;
    bus.src0_rd_en = w_rd & ~r_grant;
    bus.src1_rd_en = w_rd &  r_grant;
    bus.dst_wr_en  = w_wr;
    bus.dst_din    = (r_state == WR) ? w_src_dout : 72'h0;
    bus.trunc_err  = w_term_go;
    bus.frames0    = r_frames0;
    bus.frames1    = r_frames1;
  end
endmodule

// File: tb/tb_fifo72_tx_arbiter.sv
// Directed bench: two arbiter instances (default MAX_WORDS and MAX_WORDS=4)
// fed from simple FIFO models, write streams logged and compared to
// hand-built expected words.
module tb_fifo72_tx_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo72_tx_arbiter_if ifa();
  fifo72_tx_arbiter_if ifb();

  fifo72_tx_arbiter dut_a (.sys_clk(clk), .sys_rst(rst), .bus(ifa.master));
  fifo72_tx_arbiter #(.MAX_WORDS(4)) dut_b (.sys_clk(clk), .sys_rst(rst), .bus(ifb.master));

  // source FIFO models: dout valid the cycle after rd_en
  logic [71:0] mem0 [0:255];
  logic [71:0] mem1 [0:255];
  logic [71:0] memb [0:255];
  logic [7:0]  wp0 = 8'd0, wp1 = 8'd0, wpb = 8'd0;
  logic [7:0]  rp0 = 8'd0, rp1 = 8'd0, rpb = 8'd0;

  assign ifa.src0_empty = (wp0 == rp0);
  assign ifa.src1_empty = (wp1 == rp1);
  assign ifb.src0_empty = (wpb == rpb);
  assign ifb.src1_empty = 1'b1;
  assign ifb.src1_dout  = 72'h0;

  always @(posedge clk) begin
    if (ifa.src0_rd_en && rp0 != wp0) begin ifa.src0_dout <= mem0[rp0]; rp0 <= rp0 + 8'd1; end
    if (ifa.src1_rd_en && rp1 != wp1) begin ifa.src1_dout <= mem1[rp1]; rp1 <= rp1 + 8'd1; end
    if (ifb.src0_rd_en && rpb != wpb) begin ifb.src0_dout <= memb[rpb]; rpb <= rpb + 8'd1; end
  end

  // TX write logs
  logic [71:0] loga [0:255];
  logic [71:0] logb [0:255];
  int na = 0, nb = 0, ntrb = 0;
  always @(posedge clk) begin
    if (ifa.dst_wr_en) begin loga[na[7:0]] <= ifa.dst_din; na <= na + 1; end
    if (ifb.dst_wr_en) begin logb[nb[7:0]] <= ifb.dst_din; nb <= nb + 1; end
    if (ifb.trunc_err) ntrb <= ntrb + 1;
  end

  int nvec = 0, nmis = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] mk(input logic [7:0] mask, input int s, input int f, input int i);
    return {mask, 40'h0, 8'(s), 8'(f), 8'(i)};
  endfunction

  task automatic push0(input logic [71:0] w); mem0[wp0] = w; wp0 = wp0 + 8'd1; endtask
  task automatic push1(input logic [71:0] w); mem1[wp1] = w; wp1 = wp1 + 8'd1; endtask
  task automatic pushb(input logic [71:0] w); memb[wpb] = w; wpb = wpb + 8'd1; endtask
  task automatic tick(input int n); repeat (n) @(negedge clk); endtask

  task automatic wait_log(input bit b, input int target, input string tag);
    int c = 0;
    while (((b ? nb : na) < target) && c < 400) begin @(negedge clk); c++; end
    chk(tag, 72'(b ? nb : na), 72'(target));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, c;
    logic bad, found;
    logic [71:0] w;
    ifa.dst_full = 1'b0;
    ifb.dst_full = 1'b0;

    // reset state
    rst = 1'b1;
    tick(2);
    chk("rst_rd0",  72'(ifa.src0_rd_en), 72'd0);
    chk("rst_rd1",  72'(ifa.src1_rd_en), 72'd0);
    chk("rst_wr",   72'(ifa.dst_wr_en),  72'd0);
    chk("rst_f0",   72'(ifa.frames0),    72'd0);
    chk("rst_f1",   72'(ifa.frames1),    72'd0);
    chk("rst_trn",  72'(ifa.trunc_err),  72'd0);
    rst = 1'b0;
    tick(1);

    // 1: 3-word src0 frame, latency t+2/t+4/t+6
    push0(mk(8'hFF, 0, 0, 0)); push0(mk(8'hFF, 0, 0, 1)); push0(mk(8'h0F, 0, 0, 2));
    bad = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bad |= ifa.src1_rd_en;
      chk($sformatf("t1_rd0_c%0d", k), 72'(ifa.src0_rd_en), 72'(k % 2));
      chk($sformatf("t1_wr_c%0d", k),  72'(ifa.dst_wr_en),  72'(k % 2 == 0));
      if (k % 2 == 0) chk($sformatf("t1_din_c%0d", k), ifa.dst_din, mk((k == 6) ? 8'h0F : 8'hFF, 0, 0, k / 2 - 1));
    end
    tick(2);
    chk("t1_f0", 72'(ifa.frames0), 72'd1);
    chk("t1_rd1_quiet", 72'(bad), 72'd0);

    // 2: round-robin over 4+4 two-word frames (src1 EOF mask 00)
    rst = 1'b1; tick(1); rst = 1'b0;
    base = na;
    for (int f = 0; f < 4; f++) begin
      push0(mk(8'hFF, 0, f, 0)); push0(mk(8'h0F, 0, f, 1));
      push1(mk(8'hFF, 1, f, 0)); push1(mk(8'h00, 1, f, 1));
    end
    wait_log(1'b0, base + 16, "t2_count");
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("t2_fr%0d_w0", j), loga[8'(base + 2 * j)],     mk(8'hFF, j % 2, j / 2, 0));
      chk($sformatf("t2_fr%0d_w1", j), loga[8'(base + 2 * j + 1)], mk((j % 2) ? 8'h00 : 8'h0F, j % 2, j / 2, 1));
    end
    tick(2);
    chk("t2_f0", 72'(ifa.frames0), 72'd4);
    chk("t2_f1", 72'(ifa.frames1), 72'd4);

    // 3: dst_full stall after word 2 of a 5-word frame
    base = na;
    for (int i = 0; i < 4; i++) push0(mk(8'hFF, 0, 9, i));
    push0(mk(8'h0F, 0, 9, 4));
    found = 1'b0; c = 0;
    while (!found && c < 50) begin
      @(negedge clk); c++;
      found = ifa.dst_wr_en && (ifa.dst_din == mk(8'hFF, 0, 9, 1));
    end
    chk("t3_word2_seen", 72'(found), 72'd1);
    ifa.dst_full = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bad |= ifa.src0_rd_en | ifa.src1_rd_en | ifa.dst_wr_en;
    end
    chk("t3_stall_quiet", 72'(bad), 72'd0);
    ifa.dst_full = 1'b0;
    wait_log(1'b0, base + 5, "t3_count");
    for (int i = 0; i < 5; i++)
      chk($sformatf("t3_w%0d", i), loga[8'(base + i)], mk((i == 4) ? 8'h0F : 8'hFF, 0, 9, i));
    chk("t3_f0", 72'(ifa.frames0), 72'd5);

    // 4: src0 underruns mid-frame while src1 is ready
    base = na;
    push0(mk(8'hFF, 0, 20, 0));
    tick(1);
    push1(mk(8'h0F, 1, 20, 0));
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); bad |= ifa.src1_rd_en; end
    push0(mk(8'h0F, 0, 20, 1));
    c = 0;
    while (na < base + 2 && c < 50) begin @(negedge clk); c++; bad |= ifa.src1_rd_en; end
    chk("t4_src1_held", 72'(bad), 72'd0);
    wait_log(1'b0, base + 3, "t4_count");
    chk("t4_w0", loga[8'(base)],     mk(8'hFF, 0, 20, 0));
    chk("t4_w1", loga[8'(base + 1)], mk(8'h0F, 0, 20, 1));
    chk("t4_w2", loga[8'(base + 2)], mk(8'h0F, 1, 20, 0));
    tick(2);
    chk("t4_f0", 72'(ifa.frames0), 72'd6);
    chk("t4_f1", 72'(ifa.frames1), 72'd5);

    // 5: MAX_WORDS=4 truncation, then 1-word frame, then exact 4-word frame
    base = nb;
    for (int i = 0; i < 5; i++) pushb(mk(8'hFF, 2, 0, i));
    pushb(mk(8'h0F, 2, 0, 5));
    pushb(mk(8'h0F, 2, 1, 0));
    for (int i = 0; i < 3; i++) pushb(mk(8'hFF, 2, 2, i));
    pushb(mk(8'h0F, 2, 2, 3));
    wait_log(1'b1, base + 10, "t5_count");
    for (int i = 0; i < 4; i++) chk($sformatf("t5_w%0d", i), logb[8'(base + i)], mk(8'hFF, 2, 0, i));
    chk("t5_term", logb[8'(base + 4)], 72'h0);
    chk("t5_next", logb[8'(base + 5)], mk(8'h0F, 2, 1, 0));
    for (int i = 0; i < 4; i++)
      chk($sformatf("t5_exact_w%0d", i), logb[8'(base + 6 + i)], mk((i == 3) ? 8'h0F : 8'hFF, 2, 2, i));
    tick(4);
    chk("t5_no_extra", 72'(nb), 72'(base + 10));
    chk("t5_trunc_pulses", 72'(ntrb), 72'd1);
    chk("t5_f0", 72'(ifb.frames0), 72'd2);

    // 6: reset in the middle of a src1 frame; src0 must win afterwards
    base = na;
    push0(mk(8'h0F, 0, 40, 0));
    wait_log(1'b0, base + 1, "t6_pre");
    tick(1);
    for (int i = 0; i < 4; i++) push1(mk(8'hFF, 1, 40, i));
    push1(mk(8'h0F, 1, 40, 4));
    tick(3);
    push0(mk(8'h0F, 0, 41, 0));
    rst = 1'b1;
    tick(1);
    chk("t6_rd0",  72'(ifa.src0_rd_en), 72'd0);
    chk("t6_rd1",  72'(ifa.src1_rd_en), 72'd0);
    chk("t6_wr",   72'(ifa.dst_wr_en),  72'd0);
    chk("t6_f0",   72'(ifa.frames0),    72'd0);
    chk("t6_f1",   72'(ifa.frames1),    72'd0);
    rst = 1'b0;
    base = na;
    tick(1);
    chk("t6_first_rd0", 72'(ifa.src0_rd_en), 72'd1);
    chk("t6_first_rd1", 72'(ifa.src1_rd_en), 72'd0);
    wait_log(1'b0, base + 4, "t6_count");
    w = mk(8'h0F, 0, 41, 0);
    chk("t6_w0", loga[8'(base)], w);
    chk("t6_w1", loga[8'(base + 1)], mk(8'hFF, 1, 40, 2));
    chk("t6_w2", loga[8'(base + 2)], mk(8'hFF, 1, 40, 3));
    chk("t6_w3", loga[8'(base + 3)], mk(8'h0F, 1, 40, 4));
    tick(2);
    chk("t6_f0_end", 72'(ifa.frames0), 72'd1);
    chk("t6_f1_end", 72'(ifa.frames1), 72'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
